// File: rtl/matrix_result_serializer.sv
// Snapshots a ROWSxCOLS result matrix on done_in rise, requantizes to OUT_W and streams row-major.
// First beat 1 cycle after capture; out_* held stable under backpressure, one beat/cycle otherwise.
module matrix_result_serializer #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int IN_W    = 16,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 done_in,
    input  logic [ROWS-1:0][COLS-1:0][IN_W-1:0]  c_in,
    input  logic [SHIFT_W-1:0]                   shift_amt,
    input  logic                                 relu_en,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [OUT_W-1:0]                     out_data,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 drop_err
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(2**(OUT_W-1)));

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state_q, state_d;
    logic [N-1:0][IN_W-1:0]     buf_q, buf_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [SHIFT_W-1:0]         shift_q, shift_d;
    logic                       relu_q, relu_d;
    logic                       done_q;
    logic                       valid_q, valid_d;
    logic [OUT_W-1:0]           data_q, data_d;
    logic                       last_q, last_d;
    logic                       busy_q, busy_d;
    logic                       fdone_q, fdone_d;
    logic                       drop_q, drop_d;
    logic                       cap;
    logic [IDX_W-1:0]           idx_nxt;

    // Arithmetic shift, optional ReLU, then saturate; no rounding.
    function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] x,
                                               input logic [SHIFT_W-1:0] sh,
                                               input logic relu);
        logic signed [IN_W-1:0] s;
        s = $signed(x) >>> sh;
        if (relu && (s < 0)) s = '0;
        if (s > MAX_V)      s = MAX_V;
        else if (s < MIN_V) s = MIN_V;
        return s[OUT_W-1:0];
    endfunction

    assign cap     = done_in & ~done_q;
    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        busy_d  = busy_q;
        fdone_d = 1'b0;
        // A capture edge while a frame is in flight (including its final beat) is dropped.
        drop_d  = drop_q | (cap & busy_q);
        case (state_q)
            IDLE: begin
                if (cap) begin
                    buf_d   = c_in;
                    shift_d = shift_amt;
                    relu_d  = relu_en;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    data_d  = quant(c_in[0][0], shift_amt, relu_en);
                    last_d  = (N == 1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_q && out_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d  = idx_nxt;
                        data_d = quant(buf_q[idx_nxt], shift_q, relu_q);
                        last_d = (idx_nxt == LAST_IDX);
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        fdone_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            done_q  <= done_in;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign busy       = busy_q;
    assign frame_done = fdone_q;
    assign drop_err   = drop_q;
endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: capture, requantization, backpressure, retrigger, reset abort.
module tb_matrix_result_serializer;
    logic                      clk;
    logic                      rst_n;
    logic                      done_in;
    logic [3:0][3:0][15:0]     c_in;
    logic [3:0]                shift_amt;
    logic                      relu_en;
    logic                      out_valid;
    logic                      out_ready;
    logic [7:0]                out_data;
    logic                      out_last;
    logic                      busy;
    logic                      frame_done;
    logic                      drop_err;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;
    logic [7:0] exp_q [16];

    matrix_result_serializer #(.ROWS(4), .COLS(4), .IN_W(16), .OUT_W(8), .SHIFT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .done_in    (done_in),
        .c_in       (c_in),
        .shift_amt  (shift_amt),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hook: 0 none, 1 done_in pulse + c_in change, 2 relu/shift/c_in change, 3 async reset
    task automatic run_frame(input string tag, input int rdy_mode, input int hook,
                             input int hook_at, input bit hold);
        int n;
        bit stall;
        bit hooked;
        bit clr_pulse;
        logic [7:0] sd;
        logic sl;
        n = 0; stall = 0; hooked = 0; clr_pulse = 0; sd = '0; sl = 0;
        done_in = 1'b1;
        tick();
        check({tag, "_lat_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        if (!hold) done_in = 1'b0;
        for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
            if (stall) begin
                check({tag, "_stall_data"}, {24'b0, out_data}, {24'b0, sd});
                check({tag, "_stall_last"}, {31'b0, out_last}, {31'b0, sl});
            end
            if (clr_pulse) begin
                done_in = 1'b0;
                clr_pulse = 0;
            end
            if (!hooked && hook != 0 && n == hook_at) begin
                hooked = 1;
                case (hook)
                    1: begin
                        done_in = 1'b1;
                        clr_pulse = 1;
                        for (int i = 0; i < 4; i++)
                            for (int j = 0; j < 4; j++) c_in[i][j] = 16'h7F7F;
                    end
                    2: begin
                        relu_en = ~relu_en;
                        shift_amt = 4'd3;
                        for (int i = 0; i < 4; i++)
                            for (int j = 0; j < 4; j++) c_in[i][j] = 16'h7FFF;
                    end
                    default: begin
                        rst_n = 1'b0;
                        #1;
                        check({tag, "_rst_valid"}, {31'b0, out_valid}, 32'd0);
                        check({tag, "_rst_busy"}, {31'b0, busy}, 32'd0);
                        check({tag, "_rst_last"}, {31'b0, out_last}, 32'd0);
                        check({tag, "_rst_fdone"}, {31'b0, frame_done}, 32'd0);
                        return;
                    end
                endcase
            end
            out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            stall = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                check($sformatf("%s_data%0d", tag, n), {24'b0, out_data}, {24'b0, exp_q[n]});
                check($sformatf("%s_last%0d", tag, n), {31'b0, out_last}, {31'b0, (n == 15)});
                n++;
            end
            sd = out_data;
            sl = out_last;
            tick();
        end
        check({tag, "_beats"}, n, 32'd16);
        check({tag, "_fdone"}, {31'b0, frame_done}, 32'd1);
        check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, "_valid_end"}, {31'b0, out_valid}, 32'd0);
        tick();
        check({tag, "_fdone_pulse"}, {31'b0, frame_done}, 32'd0);
    endtask

    task automatic ramp(input int base);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                c_in[i][j] = 16'(base + i * 4 + j);
                exp_q[i * 4 + j] = 8'(base + i * 4 + j);
            end
    endtask

    task automatic zero_mat();
        c_in = '0;
        for (int k = 0; k < 16; k++) exp_q[k] = 8'h00;
    endtask

    initial begin
        int vcnt;
        int fcnt;
        rst_n = 1'b0; done_in = 1'b0; c_in = '0; shift_amt = '0; relu_en = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", {24'b0, out_data}, 32'd0);
        check("rst_last", {31'b0, out_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_fdone", {31'b0, frame_done}, 32'd0);
        check("rst_drop", {31'b0, drop_err}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Ready with nothing valid does nothing
        out_ready = 1'b1;
        tick(); tick();
        check("idle_ready_valid", {31'b0, out_valid}, 32'd0);
        check("idle_ready_busy", {31'b0, busy}, 32'd0);

        // 1: basic ramp
        ramp(0);
        run_frame("t1", 0, 0, 0, 0);

        // 2: saturation, shift 0 then shift 2
        zero_mat();
        c_in[0][0] = 16'hFF01; c_in[0][1] = 16'h0190; c_in[0][2] = 16'hFFFE;
        exp_q[0] = 8'h80; exp_q[1] = 8'h7F; exp_q[2] = 8'hFE;
        run_frame("t2s0", 0, 0, 0, 0);
        shift_amt = 4'd2;
        exp_q[0] = 8'hC0; exp_q[1] = 8'h64; exp_q[2] = 8'hFF;
        run_frame("t2s2", 0, 0, 0, 0);

        // 3: ReLU latched at capture; mid-frame input changes ignored
        zero_mat();
        shift_amt = 4'd0; relu_en = 1'b1;
        c_in[0][0] = 16'hFF9C; c_in[0][1] = 16'h0032; c_in[0][2] = 16'hFFFF;
        exp_q[1] = 8'h32;
        run_frame("t3", 0, 2, 1, 0);
        relu_en = 1'b0; shift_amt = 4'd0;

        // 4: backpressure
        ramp(16);
        run_frame("t4", 1, 0, 0, 0);
        out_ready = 1'b1;

        // 5: held done_in gives one frame only
        ramp(0);
        run_frame("t5hold", 0, 0, 0, 1);
        vcnt = 0; fcnt = 0;
        for (int c = 0; c < 24; c++) begin
            if (out_valid) vcnt++;
            if (frame_done) fcnt++;
            tick();
        end
        check("t5hold_no_retrig_valid", vcnt, 32'd0);
        check("t5hold_no_retrig_fdone", fcnt, 32'd0);
        check("t5_drop_before", {31'b0, drop_err}, 32'd0);
        done_in = 1'b0;
        tick();

        // 5: pulse during beat 5 is dropped, drop_err sticks
        ramp(32);
        run_frame("t5drop", 0, 1, 5, 0);
        check("t5_drop_set", {31'b0, drop_err}, 32'd1);
        ramp(48);
        run_frame("t5next", 0, 0, 0, 0);
        check("t5_drop_sticky", {31'b0, drop_err}, 32'd1);

        // 6: async reset at beat 7 aborts; next frame is complete
        ramp(0);
        run_frame("t6rst", 0, 3, 7, 0);
        done_in = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_fdone", {31'b0, frame_done}, 32'd0);
        check("t6_post_valid", {31'b0, out_valid}, 32'd0);
        check("t6_post_drop", {31'b0, drop_err}, 32'd0);
        ramp(64);
        run_frame("t6new", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
